// File: rtl/regfile_debug_master_if.sv
// Command, load-stream, dump-stream and register-file port bundle for regfile_debug_master.
// The slave modport is the debug master itself; master is the surrounding agent + register file.
interface regfile_debug_master_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_first;
    logic [3:0]        cmd_count;

    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;

    logic              dp_valid;
    logic              dp_ready;
    logic [DATA_W-1:0] dp_data;
    logic [ADDR_W-1:0] dp_addr;

    logic [ADDR_W-1:0] rf_readreg;
    logic [DATA_W-1:0] rf_readdata;
    logic [ADDR_W-1:0] rf_writereg;
    logic [DATA_W-1:0] rf_writedata;
    logic              rf_regwrite;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_first, cmd_count,
        output ld_valid, ld_data,
        output dp_ready,
        output rf_readdata,
        input  cmd_ready, ld_ready,
        input  dp_valid, dp_data, dp_addr,
        input  rf_readreg, rf_writereg, rf_writedata, rf_regwrite,
        input  busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_first, cmd_count,
        input  ld_valid, ld_data,
        input  dp_ready,
        input  rf_readdata,
        output cmd_ready, ld_ready,
        output dp_valid, dp_data, dp_addr,
        output rf_readreg, rf_writereg, rf_writedata, rf_regwrite,
        output busy, done, err
    );
endinterface

// File: rtl/regfile_debug_master.sv
// Debug/boot initiator for the register file: bulk-loads a register range from a word
// stream or dumps a range to an output stream, owning the register file ports while busy.
module regfile_debug_master #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter bit PROTECT_R0 = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_debug_master_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_LOAD,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_remaining;
    logic [ADDR_W-1:0] r_readreg;
    logic [DATA_W-1:0] r_dp_data;
    logic [ADDR_W-1:0] r_dp_addr;
    logic              r_dp_valid;
    logic              r_ld_ready;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_count_ok;
    logic              w_last;
    logic              w_r0_blocked;
    logic [ADDR_W-1:0] w_addr_inc;

    assign w_count_ok   = (bus.cmd_count != 4'd0) && (32'(bus.cmd_count) <= NREGS);
    assign w_last       = (r_remaining == 4'd1);
    assign w_r0_blocked = PROTECT_R0 && (r_addr == '0);
    assign w_addr_inc   = r_addr + ADDR_W'(1);

    // Write strobe is combinational so each load word lands on its own handshake edge.
    // r_ld_ready mirrors the LOAD state and is cleared asynchronously by reset.
    assign bus.rf_regwrite  = r_ld_ready && bus.ld_valid && !w_r0_blocked;
    assign bus.rf_writereg  = r_addr;
    assign bus.rf_writedata = bus.ld_data;
    assign bus.rf_readreg   = r_readreg;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.ld_ready  = r_ld_ready;
    assign bus.dp_valid  = r_dp_valid;
    assign bus.dp_data   = r_dp_data;
    assign bus.dp_addr   = r_dp_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_readreg   <= '0;
            r_dp_data   <= '0;
            r_dp_addr   <= '0;
            r_dp_valid  <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    // cmd_ready only rises one edge after reset release, so gate on it
                    if (r_cmd_ready && bus.cmd_valid) begin
                        r_addr      <= bus.cmd_first;
                        r_remaining <= bus.cmd_count;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (!w_count_ok) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (bus.cmd_op) begin
                            r_state    <= S_LOAD;
                            r_ld_ready <= 1'b1;
                        end else begin
                            r_state   <= S_DUMP_RD;
                            r_readreg <= bus.cmd_first;
                        end
                    end
                end

                S_DUMP_RD: begin
                    r_dp_data  <= bus.rf_readdata;
                    r_dp_addr  <= r_addr;
                    r_dp_valid <= 1'b1;
                    r_state    <= S_DUMP_OUT;
                end

                S_DUMP_OUT: begin
                    if (bus.dp_ready) begin
                        r_dp_valid  <= 1'b0;
                        r_addr      <= w_addr_inc;
                        r_remaining <= r_remaining - 4'd1;
                        if (w_last) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_state   <= S_DUMP_RD;
                            r_readreg <= w_addr_inc;
                        end
                    end
                end

                S_LOAD: begin
                    if (bus.ld_valid) begin
                        r_addr      <= w_addr_inc;
                        r_remaining <= r_remaining - 4'd1;
                        if (w_last) begin
                            r_ld_ready <= 1'b0;
                            r_state    <= S_FIN;
                            r_done     <= 1'b1;
                            r_err      <= 1'b0;
                        end
                    end
                end

                S_FIN: begin
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_dp_valid  <= 1'b0;
                    r_ld_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_err       <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_debug_master.sv
// Randomized bench for regfile_debug_master: a register array stands in for the register
// file, a command-level model predicts writes/dumps/done, and a monitor scores them.
module tb_regfile_debug_master;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ad_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_mem = 1'b1;
    always #5 clk = ~clk;

    regfile_debug_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_debug_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROTECT_R0(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Register file stand-in: combinational read, write at the clock edge
    logic [DATA_W-1:0] rf_mem [NREGS];
    assign bus.rf_readdata = rf_mem[bus.rf_readreg];
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
        end else if (bus.rf_regwrite) begin
            rf_mem[bus.rf_writereg] <= bus.rf_writedata;
        end
    end

    // Reference model state and scoreboard queues
    logic [DATA_W-1:0] ref_regs [NREGS];
    logic [DATA_W-1:0] ld_words[$];
    ad_t  exp_wr[$];
    ad_t  exp_dp[$];
    logic exp_done[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int done_cyc = 0;
    int dp_mode = 0;   // 0: always ready, 1: toggle, 2: random
    bit ld_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // dp_ready driver, changes just after each rising edge
    initial begin
        bus.dp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (dp_mode == 0)      bus.dp_ready = 1'b1;
            else if (dp_mode == 1) bus.dp_ready = ~bus.dp_ready;
            else                   bus.dp_ready = ($urandom % 3) != 0;
        end
    end

    // Monitor: pop and compare whenever the DUT presents a write, dump beat or done
    initial begin
        ad_t  e;
        ad_t  held;
        logic held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (bus.rf_regwrite) begin
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wr_unexpected got a=%0d d=%0h exp none", bus.rf_writereg, bus.rf_writedata);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", 32'(bus.rf_writereg), 32'(e.a));
                        chk("wr_data", 32'(bus.rf_writedata), 32'(e.d));
                    end
                end
                if (held_v && bus.dp_valid) begin
                    chk("dp_hold_addr", 32'(bus.dp_addr), 32'(held.a));
                    chk("dp_hold_data", 32'(bus.dp_data), 32'(held.d));
                end
                if (bus.dp_valid && bus.dp_ready) begin
                    if (exp_dp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL dp_unexpected got a=%0d d=%0h exp none", bus.dp_addr, bus.dp_data);
                    end else begin
                        e = exp_dp.pop_front();
                        chk("dp_addr", 32'(bus.dp_addr), 32'(e.a));
                        chk("dp_data", 32'(bus.dp_data), 32'(e.d));
                    end
                end
                held_v = bus.dp_valid && !bus.dp_ready;
                held.a = bus.dp_addr;
                held.d = bus.dp_data;
                if (bus.done) begin
                    done_cyc = cyc;
                    if (exp_done.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL done_unexpected got err=%0d exp no done", bus.err);
                    end else begin
                        chk("done_err", 32'(bus.err), 32'(exp_done.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(bus.cmd_ready && !bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL idle_timeout got busy=%0d exp idle within 300 cycles", bus.busy);
        end
    endtask

    // Issue one command; the model predicts its effect from the command alone
    task automatic issue(input logic op, input int first, input int count, input bit intrude);
        bit   legal;
        int   a;
        ad_t  e;
        int   idx;
        int   guard;
        logic hs;
        legal = (count >= 1) && (count <= NREGS);
        if (!legal) begin
            exp_done.push_back(1'b1);
        end else begin
            for (int i = 0; i < count; i++) begin
                a = (first + i) % NREGS;
                if (op) begin
                    if (a != 0) begin
                        e.a = ADDR_W'(a); e.d = ld_words[i];
                        exp_wr.push_back(e);
                        ref_regs[a] = ld_words[i];
                    end
                end else begin
                    e.a = ADDR_W'(a); e.d = ref_regs[a];
                    exp_dp.push_back(e);
                end
            end
            exp_done.push_back(1'b0);
        end
        $display("cmd op=%0d first=%0d count=%0d", op, first, count);

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_first = ADDR_W'(first);
        bus.cmd_count = 4'(count);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        bus.cmd_valid = 1'b0;

        if (op && legal) begin
            idx = 0;
            guard = 0;
            while (idx < count && guard < 200) begin
                bus.ld_valid = ld_stall ? (($urandom % 3) != 0) : 1'b1;
                bus.ld_data  = ld_words[idx];
                @(negedge clk);
                hs = bus.ld_valid && bus.ld_ready;
                @(posedge clk);
                #1;
                if (hs) idx++;
                guard++;
            end
            bus.ld_valid = 1'b0;
        end

        if (!op && legal && intrude) begin
            repeat (2) @(posedge clk);
            #1;
            if (bus.busy) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 1'b1;
                bus.cmd_first = ADDR_W'(first + 3);
                bus.cmd_count = 4'd2;
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
            end
        end
        wait_idle();
    endtask

    task automatic set_words(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                             input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
        ld_words = {};
        ld_words.push_back(w0);
        ld_words.push_back(w1);
        ld_words.push_back(w2);
        ld_words.push_back(w3);
    endtask

    initial begin
        int op, first, count;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_first = '0;
        bus.cmd_count = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        for (int i = 0; i < NREGS; i++) ref_regs[i] = '0;

        // Reset state
        #12;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_dp_valid", 32'(bus.dp_valid), 0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 0);
        chk("rst_regwrite", 32'(bus.rf_regwrite), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_readreg", 32'(bus.rf_readreg), 0);
        chk("rst_dp_data", 32'(bus.dp_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mem = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);

        // Load r1..r3 back-to-back, done one cycle after the last write
        dp_mode = 0; ld_stall = 1'b0;
        set_words(16'd10, 16'd20, 16'd30, 16'd0);
        issue(1'b1, 1, 3, 1'b0);
        chk("load3_done_latency", 32'(done_cyc - accept_cyc), 3);
        issue(1'b0, 1, 3, 1'b0);

        // Wrapping load then dump 6,7,0,1 with toggling dp_ready
        set_words(16'd60, 16'd70, 16'd0, 16'd11);
        issue(1'b1, 6, 4, 1'b0);
        dp_mode = 1;
        issue(1'b0, 6, 4, 1'b0);

        // Register 0 protected: word consumed, no write
        dp_mode = 0;
        set_words(16'd99, 16'd5, 16'd0, 16'd0);
        issue(1'b1, 0, 2, 1'b0);

        // Illegal counts
        issue(1'b0, 3, 0, 1'b0);
        chk("err0_done_latency", 32'(done_cyc - accept_cyc), 0);
        issue(1'b1, 3, 9, 1'b0);
        chk("err9_done_latency", 32'(done_cyc - accept_cyc), 0);

        // Command offered mid-dump is ignored
        dp_mode = 2;
        issue(1'b0, 0, 8, 1'b1);

        // Reset during LOAD with ld_valid high
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_first = 3'd2; bus.cmd_count = 4'd3;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.ld_valid  = 1'b1;
        bus.ld_data   = 16'hBEEF;
        #1;
        chk("rst_mid_pre_regwrite", 32'(bus.rf_regwrite), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async_regwrite", 32'(bus.rf_regwrite), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        bus.ld_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_mid_busy_after", 32'(bus.busy), 0);
        chk("rst_mid_done", 32'(bus.done), 0);
        @(negedge clk);
        issue(1'b0, 1, 3, 1'b0);

        // Randomized commands
        for (int t = 0; t < 40; t++) begin
            op    = $urandom % 2;
            first = $urandom % NREGS;
            count = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : 9 + ($urandom % 7))
                                          : 1 + ($urandom % NREGS);
            dp_mode  = $urandom % 3;
            ld_stall = ($urandom % 2) != 0;
            ld_words = {};
            for (int i = 0; i < 16; i++) ld_words.push_back(DATA_W'($urandom));
            issue(op[0], first, count, ($urandom % 2) != 0);
        end

        // Final dump of the whole file against the model
        dp_mode = 0;
        issue(1'b0, 0, 8, 1'b0);

        chk("queues_drained", 32'(exp_wr.size() + exp_dp.size() + exp_done.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
